shift_sequencer: RTL and testbench

Multi-cycle controller that turns the single-bit shift unit into an N-bit logical shifter. It accepts one shift request at a time over a valid/ready handshake and drives the shift unit once per bit. It feeds each registered result back as the next operand and returns the final value over a second valid/ready handshake. It sits between the ALU operation decoder and the shift unit; it owns the unit's `shift_en`, `shift_fun` and `in1` inputs.

---
 rtl/shift_sequencer_if.sv | 34 +++
 rtl/shift_sequencer.sv | 129 ++++++++++++
 tb/tb_shift_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Request, response and shift-unit signal bundle for shift_sequencer.
// master = surrounding environment (decoder, consumer, shift unit); slave = the sequencer.
interface shift_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int AMT_WIDTH  = 5
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  req_dir;
    logic [AMT_WIDTH-1:0]  req_amt;

    logic [DATA_WIDTH-1:0] su_in1;
    logic [DATA_WIDTH-1:0] su_in2;
    logic [1:0]            su_fun;
    logic                  su_en;
    logic [DATA_WIDTH-1:0] su_out;
    logic                  su_flag;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

    modport master (
        output req_valid, req_data, req_dir, req_amt, rsp_ready, su_out, su_flag,
        input  req_ready, su_in1, su_in2, su_fun, su_en, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_data, req_dir, req_amt, rsp_ready, su_out, su_flag,
        output req_ready, su_in1, su_in2, su_fun, su_en, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/shift_sequencer.sv
// N-bit logical shifter built by iterating a 1-bit shift unit; 2*amt+1 cycles per request, response held under backpressure.
// SHIFT_SEQ_SAT_EN: amounts >= DATA_WIDTH skip iteration and answer 0 after one cycle.
module shift_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int AMT_WIDTH  = 5
) (
    input logic          clk,
    input logic          rst_n,
    shift_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] work_q, work_d;
    logic [AMT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  dir_q, dir_d;
    logic                  err_q, err_d;

    logic                  req_ready_q;
    logic                  su_en_q;
    logic [1:0]            su_fun_q;
    logic [DATA_WIDTH-1:0] su_in1_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_err_q;

`ifdef SHIFT_SEQ_SAT_EN
    localparam logic [AMT_WIDTH:0] AMT_LIMIT = (AMT_WIDTH+1)'(DATA_WIDTH);
    logic sat_amt;
    assign sat_amt = ({1'b0, bus.req_amt} >= AMT_LIMIT);
`endif

    // Datapath next values; a saturated request is loaded as an already-finished zero shift.
    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        err_d  = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    work_d = bus.req_data;
                    cnt_d  = bus.req_amt;
                    dir_d  = bus.req_dir;
                    err_d  = 1'b0;
`ifdef SHIFT_SEQ_SAT_EN
                    if (sat_amt) begin
                        work_d = '0;
                        cnt_d  = '0;
                    end
`endif
                end
            end
            S_WAIT: begin
                work_d = bus.su_out;
                cnt_d  = cnt_q - 1'b1;
                if (!bus.su_flag) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            su_en_q     <= 1'b0;
            su_fun_q    <= 2'b00;
            su_in1_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            err_q  <= err_d;
            case (state_q)
                S_IDLE, S_WAIT: begin
                    if (state_q == S_WAIT || bus.req_valid) begin
                        req_ready_q <= 1'b0;
                        if (cnt_d == '0) begin
                            state_q     <= S_DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= work_d;
                            rsp_err_q   <= err_d;
                        end else begin
                            state_q  <= S_ISSUE;
                            su_en_q  <= 1'b1;
                            su_fun_q <= {1'b0, dir_d};
                            su_in1_q <= work_d;
                        end
                    end
                end
                S_ISSUE: begin
                    state_q  <= S_WAIT;
                    su_en_q  <= 1'b0;
                    su_fun_q <= 2'b00;
                    su_in1_q <= '0;
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        state_q     <= S_IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.su_en     = su_en_q;
    assign bus.su_fun    = su_fun_q;
    assign bus.su_in1    = su_in1_q;
    assign bus.su_in2    = '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer with a behavioural 1-bit shift unit attached.
module tb_shift_sequencer;
    localparam int DW = 16;
    localparam int AW = 5;

    typedef struct {
        logic [DW-1:0] op;
        logic          dir;
        logic [DW-1:0] data;
        logic          err;
        int            lat;
        int            pulses;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    shift_sequencer_if #(.DATA_WIDTH(DW), .AMT_WIDTH(AW)) bus ();

    shift_sequencer #(.DATA_WIDTH(DW), .AMT_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rdy_mode = 1;
    int   drop_pulse = 0;
    int   su_pcnt = 0;
    exp_t exp_q[$];

    int            accept_cyc = 0;
    int            last_rsp_cyc = 0;
    int            last_gap = 0;
    int            pulses = 0;
    int            aux_bad = 0;
    int            lat = 0;
    bit            in_flight = 0;
    bit            rsp_seen = 0;
    bit            hold_prev = 0;
    logic [DW-1:0] hold_data;
    logic          hold_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_pulses(input logic [AW-1:0] a);
`ifdef SHIFT_SEQ_SAT_EN
        if (int'(a) >= DW) return 0;
`endif
        return int'(a);
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.rsp_ready = 1'b0;
            1:       bus.rsp_ready = 1'b1;
            default: bus.rsp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Shift unit: registered result one cycle after su_en; flag withheld on the chosen pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.su_out  <= '0;
            bus.su_flag <= 1'b0;
            su_pcnt     <= 0;
        end else begin
            if (bus.req_valid && bus.req_ready) su_pcnt <= 0;
            else if (bus.su_en) su_pcnt <= su_pcnt + 1;
            bus.su_flag <= bus.su_en && (su_pcnt + 1 != drop_pulse);
            if (bus.su_en) bus.su_out <= bus.su_fun[0] ? bus.su_in1 << 1 : bus.su_in1 >> 1;
        end
    end

    // Monitor: tracks the in-flight request and compares each accepted response.
    always @(negedge clk) begin
        exp_t e;
        logic [DW-1:0] exp_in1;
        if (!rst_n) begin
            in_flight = 0;
            rsp_seen  = 0;
            hold_prev = 0;
        end else begin
            if (in_flight && bus.req_ready) aux_bad++;
            if (bus.su_en) begin
                pulses++;
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    exp_in1 = e.dir ? e.op << (pulses - 1) : e.op >> (pulses - 1);
                    if (bus.su_fun !== {1'b0, e.dir} || bus.su_in1 !== exp_in1) aux_bad++;
                end else begin
                    aux_bad++;
                end
            end else if (bus.su_fun !== 2'b00 || bus.su_in1 !== '0) begin
                aux_bad++;
            end
            if (bus.su_in2 !== '0) aux_bad++;
            if (hold_prev && (!bus.rsp_valid || bus.rsp_data !== hold_data || bus.rsp_err !== hold_err))
                aux_bad++;
            if (bus.rsp_valid && !rsp_seen) begin
                rsp_seen = 1;
                lat = cyc + 1 - accept_cyc;
            end
            hold_prev = bus.rsp_valid && !bus.rsp_ready;
            hold_data = bus.rsp_data;
            hold_err  = bus.rsp_err;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: got data %0h with no request pending", bus.rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                    chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    chk("latency", 64'(lat), 64'(e.lat));
                    chk("su_en_pulses", 64'(pulses), 64'(e.pulses));
                    chk("side_rules", 64'(aux_bad), 64'd0);
                end
                in_flight    = 0;
                rsp_seen     = 0;
                last_rsp_cyc = cyc + 1;
            end
            if (bus.req_valid && bus.req_ready) begin
                accept_cyc = cyc + 1;
                last_gap   = accept_cyc - last_rsp_cyc;
                in_flight  = 1;
                pulses     = 0;
                aux_bad    = 0;
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic dr, input logic [AW-1:0] a, input logic e_err);
        exp_t e;
        int   n;
        e.op     = d;
        e.dir    = dr;
        e.data   = dr ? d << a : d >> a;
        e.err    = e_err;
        e.pulses = exp_pulses(a);
        e.lat    = 2 * e.pulses + 1;
        exp_q.push_back(e);
        bus.req_valid = 1'b1;
        bus.req_data  = d;
        bus.req_dir   = dr;
        bus.req_amt   = a;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            n++;
            if (n > 300) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: req_ready still %0b after %0d cycles", bus.req_ready, n);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_data  = DW'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d responses outstanding, 0 required", exp_q.size());
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err,
                   bus.su_en, bus.su_fun, bus.su_in1, bus.su_in2},
            {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0});
    endtask

    initial begin
        int seen_rdy;
        int n;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_data  = '0;
        bus.req_dir   = 1'b0;
        bus.req_amt   = '0;
        #12;
        check_reset_outputs("reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(16'hF0F0, 1'b0, 5'd4, 1'b0);
        wait_drain();

        send(16'h0001, 1'b1, 5'd15, 1'b0);
        send(16'hABCD, 1'b0, 5'd0, 1'b0);
        chk("back_to_back_gap", 64'(last_gap), 64'd1);
        wait_drain();

        send(16'hFFFF, 1'b0, 5'd20, 1'b0);
        send(16'hFFFF, 1'b1, 5'd16, 1'b0);
        wait_drain();

        // Backpressure: hold the response and offer a second request meanwhile.
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send(16'h1234, 1'b1, 5'd2, 1'b0);
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_data  = 16'h5A5A;
        bus.req_dir   = 1'b0;
        bus.req_amt   = 5'd1;
        seen_rdy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.req_ready || !bus.rsp_valid) seen_rdy++;
        end
        chk("bp_busy_not_ready", 64'(seen_rdy), 64'd0);
        @(posedge clk);
        #1;
        rdy_mode = 1;
        send(16'h5A5A, 1'b0, 5'd1, 1'b0);
        wait_drain();

        drop_pulse = 2;
        send(16'h1234, 1'b1, 5'd3, 1'b1);
        wait_drain();
        drop_pulse = 0;
        send(16'h8421, 1'b0, 5'd3, 1'b0);
        wait_drain();

        // Reset while the shift unit result is being captured.
        send(16'h00FF, 1'b1, 5'd6, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset_outputs");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(16'h0002, 1'b0, 5'd1, 1'b0);
        wait_drain();

        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(16, 31)) : AW'($urandom_range(0, 15));
            send(DW'($urandom), 1'($urandom_range(0, 1)), a, 1'b0);
        end
        wait_drain();
        rdy_mode = 1;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
